// File: rtl/text_pkg.sv
// Shared types and constants for the terminal-to-text-buffer writer.
package text_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUTC,
        SCRL_RD,
        SCRL_WR,
        SCRL_CLR,
        CLS
    } state_t;

    localparam int COLS      = 80;
    localparam int LINES     = 24;
    localparam int SVC_LEN   = 80;
    localparam int LAST_LINE = 1920;
    localparam int AREA_END  = 2000;

    localparam logic [7:0] CH_BS  = 8'h08;
    localparam logic [7:0] CH_LF  = 8'h0A;
    localparam logic [7:0] CH_FF  = 8'h0C;
    localparam logic [7:0] CH_CR  = 8'h0D;
    localparam logic [7:0] CH_DEL = 8'h7F;

    localparam logic [15:0] SPACE_WORD = 16'h2020;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c != CH_DEL);
    endfunction

endpackage

// File: rtl/wb_single_master.sv
// One-transfer Wishbone initiator: latches a request on start, holds it until ack.
module wb_single_master (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [15:0] adr,
    input  logic        we,
    input  logic [1:0]  sel,
    input  logic [15:0] dat,
    output logic        done,
    output logic [15:0] rdata,
    output logic [15:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    input  logic        wb_ack_i
);

    // done is the ack edge itself so the sequencer can queue the next start
    // there, leaving cyc low for exactly one clock between transfers.
    assign done = wb_cyc_o & wb_ack_i;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_we_o  <= 1'b0;
            wb_sel_o <= 2'b00;
            wb_adr_o <= 16'h0000;
            wb_dat_o <= 16'h0000;
            rdata    <= 16'h0000;
        end else if (wb_cyc_o) begin
            if (wb_ack_i) begin
                wb_cyc_o <= 1'b0;
                wb_stb_o <= 1'b0;
                rdata    <= wb_dat_i;
            end
        end else if (start) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= we;
            wb_sel_o <= sel;
            wb_adr_o <= adr;
            wb_dat_o <= dat;
        end
    end

endmodule

// File: rtl/text_writer.sv
// Turns a terminal character stream into text-buffer writes, with cursor
// tracking, CR/LF/BS/FF handling and hardware scroll/clear.
//
// state    | meaning
// IDLE     | ready for a character
// PUTC     | writing one printable character
// SCRL_RD  | scroll: reading source word
// SCRL_WR  | scroll: writing it one line up
// SCRL_CLR | scroll: blanking the last line
// CLS      | form feed: blanking the whole text area
module text_writer #(
    parameter logic [15:0] BASE  = 16'h0000,
    parameter int          COLS  = 80,
    parameter int          LINES = 24
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [7:0]  ch_i,
    input  logic        ch_valid_i,
    output logic        ch_ready_o,
    output logic        busy_o,
    output logic [15:0] wb_adr_o,
    output logic [15:0] wb_dat_o,
    input  logic [15:0] wb_dat_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [1:0]  wb_sel_o,
    input  logic        wb_ack_i,
    output logic [12:0] cursor_o,
    output logic [6:0]  col_o
);
    import text_pkg::*;

    localparam logic [12:0] SVC        = 13'(SVC_LEN);
    localparam logic [12:0] LAST_START = 13'(SVC_LEN + (LINES - 1) * COLS);
    localparam logic [12:0] LAST_WORD  = 13'(SVC_LEN + LINES * COLS - 2);
    localparam logic [12:0] SCRL_FIRST = 13'(SVC_LEN + COLS);
    localparam logic [12:0] LINE_LEN   = 13'(COLS);
    localparam logic [6:0]  COL_LAST   = 7'(COLS - 1);

    state_t      state;
    logic [12:0] src;
    logic        m_start, m_we, m_done;
    logic [12:0] m_adr;
    logic [1:0]  m_sel;
    logic [15:0] m_dat, m_rdata, wr_dat;

    assign ch_ready_o = (state == IDLE) & ~wb_rst_i;
    assign busy_o     = (state != IDLE);
    // Scroll writes forward the word captured by the preceding read.
    assign wr_dat     = (state == SCRL_WR) ? m_rdata : m_dat;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state    <= IDLE;
            cursor_o <= SVC;
            col_o    <= 7'd0;
            src      <= 13'd0;
            m_start  <= 1'b0;
            m_adr    <= 13'd0;
            m_we     <= 1'b0;
            m_sel    <= 2'b00;
            m_dat    <= 16'h0000;
        end else begin
            m_start <= 1'b0;
            case (state)
                IDLE: if (ch_valid_i) begin
                    if (is_printable(ch_i)) begin
                        state   <= PUTC;
                        m_start <= 1'b1;
                        m_adr   <= {cursor_o[12:1], 1'b0};
                        m_we    <= 1'b1;
                        m_sel   <= cursor_o[0] ? 2'b10 : 2'b01;
                        m_dat   <= {ch_i, ch_i};
                    end else begin
                        case (ch_i)
                            CH_CR: begin
                                cursor_o <= cursor_o - 13'(col_o);
                                col_o    <= 7'd0;
                            end
                            CH_LF: if (cursor_o < LAST_START) begin
                                cursor_o <= cursor_o + LINE_LEN;
                            end else begin
                                state   <= SCRL_RD;
                                src     <= SCRL_FIRST;
                                m_start <= 1'b1;
                                m_adr   <= SCRL_FIRST;
                                m_we    <= 1'b0;
                                m_sel   <= 2'b11;
                            end
                            CH_BS: if (col_o != 7'd0) begin
                                cursor_o <= cursor_o - 13'd1;
                                col_o    <= col_o - 7'd1;
                            end
                            CH_FF: begin
                                state   <= CLS;
                                src     <= SVC;
                                m_start <= 1'b1;
                                m_adr   <= SVC;
                                m_we    <= 1'b1;
                                m_sel   <= 2'b11;
                                m_dat   <= SPACE_WORD;
                            end
                            default: ;
                        endcase
                    end
                end
                PUTC: if (m_done) begin
                    if (col_o < COL_LAST) begin
                        col_o    <= col_o + 7'd1;
                        cursor_o <= cursor_o + 13'd1;
                        state    <= IDLE;
                    end else begin
                        col_o <= 7'd0;
                        if (cursor_o >= LAST_START) begin
                            cursor_o <= LAST_START;
                            state    <= SCRL_RD;
                            src      <= SCRL_FIRST;
                            m_start  <= 1'b1;
                            m_adr    <= SCRL_FIRST;
                            m_we     <= 1'b0;
                            m_sel    <= 2'b11;
                        end else begin
                            cursor_o <= cursor_o - 13'(col_o) + LINE_LEN;
                            state    <= IDLE;
                        end
                    end
                end
                SCRL_RD: if (m_done) begin
                    state   <= SCRL_WR;
                    m_start <= 1'b1;
                    m_adr   <= src - LINE_LEN;
                    m_we    <= 1'b1;
                    m_sel   <= 2'b11;
                end
                SCRL_WR: if (m_done) begin
                    m_start <= 1'b1;
                    if (src == LAST_WORD) begin
                        state <= SCRL_CLR;
                        src   <= LAST_START;
                        m_adr <= LAST_START;
                        m_we  <= 1'b1;
                        m_dat <= SPACE_WORD;
                    end else begin
                        state <= SCRL_RD;
                        src   <= src + 13'd2;
                        m_adr <= src + 13'd2;
                        m_we  <= 1'b0;
                    end
                end
                SCRL_CLR, CLS: if (m_done) begin
                    if (src == LAST_WORD) begin
                        if (state == CLS) begin
                            cursor_o <= SVC;
                            col_o    <= 7'd0;
                        end
                        state <= IDLE;
                    end else begin
                        m_start <= 1'b1;
                        src     <= src + 13'd2;
                        m_adr   <= src + 13'd2;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    wb_single_master u_master (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .start    (m_start),
        .adr      (BASE + {3'b000, m_adr}),
        .we       (m_we),
        .sel      (m_sel),
        .dat      (wr_dat),
        .done     (m_done),
        .rdata    (m_rdata),
        .wb_adr_o (wb_adr_o),
        .wb_dat_o (wb_dat_o),
        .wb_dat_i (wb_dat_i),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_we_o  (wb_we_o),
        .wb_sel_o (wb_sel_o),
        .wb_ack_i (wb_ack_i)
    );

endmodule

// File: tb/tb_text_writer.sv
// Scoreboard bench for text_writer: memory responder, cursor model, expected bus queue.
module tb_text_writer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic [7:0]  ch_i = 8'h00;
    logic        ch_valid_i = 1'b0;
    logic        ch_ready_o, busy_o;
    logic [15:0] wb_adr_o, wb_dat_o;
    logic [15:0] wb_dat_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [1:0]  wb_sel_o;
    logic        wb_ack_i;
    logic [12:0] cursor_o;
    logic [6:0]  col_o;

    text_writer dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .ch_i       (ch_i),
        .ch_valid_i (ch_valid_i),
        .ch_ready_o (ch_ready_o),
        .busy_o     (busy_o),
        .wb_adr_o   (wb_adr_o),
        .wb_dat_o   (wb_dat_o),
        .wb_dat_i   (wb_dat_i),
        .wb_cyc_o   (wb_cyc_o),
        .wb_stb_o   (wb_stb_o),
        .wb_we_o    (wb_we_o),
        .wb_sel_o   (wb_sel_o),
        .wb_ack_i   (wb_ack_i),
        .cursor_o   (cursor_o),
        .col_o      (col_o)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int n_checks = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pat(input int w);
        return 16'(w * 37 + 16'h0100);
    endfunction

    // responder memory: 1024 words, byte lanes honoured
    logic [15:0] mem [1024];
    logic [15:0] shadow [1024];
    logic        preload = 1'b0;
    int          waits = 0;
    int          wcnt;
    logic [9:0]  idx;
    assign idx = wb_adr_o[10:1];

    always @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wb_ack_i <= 1'b0;
            wb_dat_i <= 16'h0000;
            wcnt     <= 0;
        end else if (preload) begin
            for (int w = 0; w < 1024; w++) mem[w] <= pat(w);
        end else if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
            if (wcnt >= waits) begin
                wb_ack_i <= 1'b1;
                wcnt     <= 0;
                if (wb_we_o) begin
                    if (wb_sel_o[0]) mem[idx][7:0]  <= wb_dat_o[7:0];
                    if (wb_sel_o[1]) mem[idx][15:8] <= wb_dat_o[15:8];
                end else begin
                    wb_dat_i <= mem[idx];
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end else begin
            wb_ack_i <= 1'b0;
        end
    end

    // expected transactions: {we, adr, sel, dat}; read data field is zero
    logic [34:0] exp_q [$];
    logic [34:0] obs, prev_sig;
    logic        prev_pend = 1'b0;
    int          hold_err = 0;

    always @(negedge wb_clk_i) begin
        if (wb_rst_i) begin
            prev_pend = 1'b0;
        end else begin
            obs = {wb_we_o, wb_adr_o, wb_sel_o, wb_we_o ? wb_dat_o : 16'h0000};
            if (prev_pend && (!wb_cyc_o || !wb_stb_o || obs != prev_sig)) hold_err++;
            if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
                if (exp_q.size() == 0) check_eq("bus_extra", 64'(obs), 64'hFFFF_FFFF_FFFF_FFFF);
                else check_eq("bus", 64'(obs), 64'(exp_q.pop_front()));
            end
            prev_pend = wb_cyc_o && wb_stb_o && !wb_ack_i;
            prev_sig  = obs;
        end
    end

    int cur = 80;
    int col = 0;
    int rdy_busy = 0;

    task automatic push_w(input int a, input logic [15:0] d, input logic [1:0] s);
        int w;
        w = a / 2;
        exp_q.push_back({1'b1, 16'(a - (a % 2)), s, d});
        if (s[0]) shadow[w][7:0]  = d[7:0];
        if (s[1]) shadow[w][15:8] = d[15:8];
    endtask

    task automatic push_scroll();
        for (int s = 160; s < 2000; s += 2) begin
            exp_q.push_back({1'b0, 16'(s), 2'b11, 16'h0000});
            push_w(s - 80, shadow[s / 2], 2'b11);
        end
        for (int a = 1920; a < 2000; a += 2) push_w(a, 16'h2020, 2'b11);
    endtask

    task automatic model_char(input logic [7:0] c);
        if (c >= 8'h20 && c != 8'h7F) begin
            push_w(cur, {c, c}, (cur % 2 == 1) ? 2'b10 : 2'b01);
            if (col < 79) begin
                col++; cur++;
            end else if (cur >= 1920) begin
                push_scroll();
                cur = 1920; col = 0;
            end else begin
                cur = cur - col + 80; col = 0;
            end
        end else if (c == 8'h0D) begin
            cur = cur - col; col = 0;
        end else if (c == 8'h0A) begin
            if (cur < 1920) cur += 80;
            else push_scroll();
        end else if (c == 8'h08) begin
            if (col > 0) begin col--; cur--; end
        end else if (c == 8'h0C) begin
            for (int a = 80; a < 2000; a += 2) push_w(a, 16'h2020, 2'b11);
            cur = 80; col = 0;
        end
    endtask

    task automatic send_char(input logic [7:0] c);
        int n;
        model_char(c);
        @(negedge wb_clk_i);
        ch_i = c;
        ch_valid_i = 1'b1;
        n = 0;
        while (!ch_ready_o && n < 100) begin
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= 100) check_eq("accept_timeout", 64'(n), 64'(0));
        @(posedge wb_clk_i);
        #1 ch_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        @(negedge wb_clk_i);
        while (busy_o && n < 20000) begin
            if (ch_ready_o) rdy_busy++;
            @(negedge wb_clk_i);
            n++;
        end
        if (n >= 20000) check_eq({tag, "_timeout"}, 64'(n), 64'(0));
        check_eq({tag, "_cursor"}, 64'(cursor_o), 64'(cur));
        check_eq({tag, "_col"}, 64'(col_o), 64'(col));
        check_eq({tag, "_pending"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic send_wait(input logic [7:0] c, input string tag);
        send_char(c);
        wait_idle(tag);
    endtask

    task automatic do_preload();
        @(negedge wb_clk_i) preload = 1'b1;
        @(negedge wb_clk_i) preload = 1'b0;
        for (int w = 0; w < 1024; w++) shadow[w] = pat(w);
    endtask

    task automatic compare_mem(input string tag);
        int bad;
        bad = 0;
        for (int w = 0; w < 1000; w++) if (mem[w] !== shadow[w]) bad++;
        check_eq(tag, 64'(bad), 64'(0));
    endtask

    initial begin
        int bad;
        for (int w = 0; w < 1024; w++) shadow[w] = 16'h0000;
        repeat (3) @(negedge wb_clk_i);
        check_eq("rst_cursor", 64'(cursor_o), 64'(80));
        check_eq("rst_col", 64'(col_o), 64'(0));
        check_eq("rst_bus", 64'({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o}), 64'(0));
        check_eq("rst_busy", 64'(busy_o), 64'(0));
        check_eq("rst_ready", 64'(ch_ready_o), 64'(0));
        wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1 check_eq("ready_after_rst", 64'(ch_ready_o), 64'(1));
        do_preload();

        send_wait(8'h41, "char_A");
        send_wait(8'h42, "char_B");
        send_wait(8'h0D, "cr");
        send_wait(8'h0A, "lf");
        send_wait(8'h08, "bs_col0");
        send_wait(8'h7F, "del_ignored");
        send_wait(8'h01, "ctl_ignored");
        send_wait(8'hE9, "hi_char");
        send_wait(8'h08, "bs");
        compare_mem("mem_after_chars");

        // scroll from the last line
        do_preload();
        for (int i = 0; i < 22; i++) send_wait(8'h0A, "lf_down");
        rdy_busy = 0;
        send_wait(8'h0A, "scroll");
        check_eq("ready_while_busy", 64'(rdy_busy), 64'(0));
        bad = 0;
        for (int w = 0; w < 40; w++) if (mem[w] !== pat(w)) bad++;
        check_eq("service_line", 64'(bad), 64'(0));
        compare_mem("mem_after_scroll");

        // clear screen with wait states
        waits = 3;
        send_wait(8'h0C, "clear");
        waits = 0;
        compare_mem("mem_after_clear");

        // wrap on an ordinary line, then on the last line
        for (int i = 0; i < 80; i++) send_wait(8'(8'h61 + i % 26), "wrap_line");
        for (int i = 0; i < 22; i++) send_wait(8'h0A, "lf_down2");
        for (int i = 0; i < 80; i++) send_wait(8'(8'h41 + i % 26), "wrap_last");
        compare_mem("mem_after_wrap_scroll");
        check_eq("hold_violations", 64'(hold_err), 64'(0));

        // reset in the middle of a scroll
        send_char(8'h0A);
        repeat (100) @(negedge wb_clk_i);
        #2 wb_rst_i = 1'b1;
        #1;
        check_eq("midrst_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'(0));
        check_eq("midrst_cursor", 64'(cursor_o), 64'(80));
        check_eq("midrst_col", 64'(col_o), 64'(0));
        exp_q.delete();
        cur = 80; col = 0;
        @(negedge wb_clk_i) wb_rst_i = 1'b0;
        @(posedge wb_clk_i);
        #1 check_eq("midrst_ready", 64'(ch_ready_o), 64'(1));
        check_eq("midrst_busy", 64'(busy_o), 64'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
